// File: rtl/ds_pkg.sv
// rtl/ds_pkg.sv - shared types and scale helpers for ds_frame_ctrl
package ds_pkg;

  typedef enum logic [1:0] {
    SCALE_1 = 2'd0,
    SCALE_2 = 2'd1,
    SCALE_4 = 2'd2
  } ds_scale_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    LINE  = 2'd2
  } ds_state_e;

  // The reserved code 3 behaves exactly like 1/4.
  function automatic ds_scale_e to_scale(input logic [1:0] raw);
    case (raw)
      2'd0:    return SCALE_1;
      2'd1:    return SCALE_2;
      default: return SCALE_4;
    endcase
  endfunction

  function automatic logic [1:0] scale_mask(input ds_scale_e s);
    case (s)
      SCALE_1: return 2'd0;
      SCALE_2: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/ds_edge_det.sv
// rtl/ds_edge_det.sv - rising/falling edge detect against the previous registered sample
module ds_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prev <= 1'b0;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/ds_frame_ctrl.sv
// rtl/ds_frame_ctrl.sv - downscaler frame controller: counters, keep strobe, frame-committed config
// Optional line-length error check is built when DS_CTRL_ERR_EN is defined.
import ds_pkg::*;

module ds_frame_ctrl #(
  parameter int HCNT_W = 12,
  parameter int VCNT_W = 11,
  parameter int H_ACT  = 1920
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_vsync,
  input  logic              i_hsync,
  input  logic              i_de,
  input  logic              i_cfg_valid,
  input  logic              i_cfg_gray,
  input  logic [1:0]        i_cfg_scale,
  output logic              o_vsync,
  output logic              o_hsync,
  output logic              o_de,
  output logic              o_keep,
  output logic              o_gray_sel,
  output logic [1:0]        o_scale,
  output logic [HCNT_W-1:0] o_x,
  output logic [VCNT_W-1:0] o_y,
  output logic [7:0]        o_frame_cnt,
  output logic              o_err
);

  logic vs_rise, vs_fall, de_rise, de_fall;

  ds_edge_det u_vs_edge (.clk(clk), .rstn(rstn), .sig(i_vsync), .rise(vs_rise), .fall(vs_fall));
  ds_edge_det u_de_edge (.clk(clk), .rstn(rstn), .sig(i_de),    .rise(de_rise), .fall(de_fall));

  ds_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (vs_rise) begin
      state_d = BLANK;
    end else begin
      case (state_q)
        BLANK:   if (i_de)  state_d = LINE;
        LINE:    if (!i_de) state_d = BLANK;
        default: state_d = state_q;
      endcase
    end
  end

  logic              pend_gray, gray_q, gray_d;
  ds_scale_e         pend_scale, scale_q, scale_d;
  logic [HCNT_W-1:0] x_q, x_d;
  logic [VCNT_W-1:0] y_q, y_d;
  logic              in_frame, line_end, keep_d;
  logic [1:0]        mask;

  always_comb begin
    in_frame = (state_q != IDLE) || vs_rise;
    // LINE is only entered with DE high, so a fall seen in LINE always closes an in-frame line.
    line_end = de_fall && (state_q == LINE) && !vs_rise;
    gray_d   = gray_q;
    scale_d  = scale_q;
    x_d      = x_q;
    y_d      = y_q;
    if (vs_rise) begin
      gray_d  = i_cfg_valid ? i_cfg_gray : pend_gray;
      scale_d = i_cfg_valid ? to_scale(i_cfg_scale) : pend_scale;
      x_d     = '0;
      y_d     = '0;
    end else begin
      if (in_frame && i_de) x_d = de_rise ? '0 : ((x_q == '1) ? x_q : x_q + 1'b1);
      if (line_end)         y_d = (y_q == '1) ? y_q : y_q + 1'b1;
    end
    mask   = scale_mask(scale_d);
    keep_d = i_de && in_frame && ((x_d[1:0] & mask) == 2'd0) && ((y_d[1:0] & mask) == 2'd0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_gray   <= 1'b0;
      pend_scale  <= SCALE_1;
      gray_q      <= 1'b0;
      scale_q     <= SCALE_1;
      x_q         <= '0;
      y_q         <= '0;
      o_vsync     <= 1'b0;
      o_hsync     <= 1'b0;
      o_de        <= 1'b0;
      o_keep      <= 1'b0;
      o_frame_cnt <= 8'd0;
    end else begin
      if (i_cfg_valid) begin
        pend_gray  <= i_cfg_gray;
        pend_scale <= to_scale(i_cfg_scale);
      end
      gray_q      <= gray_d;
      scale_q     <= scale_d;
      x_q         <= x_d;
      y_q         <= y_d;
      o_vsync     <= i_vsync;
      o_hsync     <= i_hsync;
      o_de        <= i_de && in_frame;
      o_keep      <= keep_d;
      if (vs_rise) o_frame_cnt <= o_frame_cnt + 8'd1;
    end
  end

  assign o_gray_sel = gray_q;
  assign o_scale    = scale_q;
  assign o_x        = x_q;
  assign o_y        = y_q;

  logic unused_sig;

`ifdef DS_CTRL_ERR_EN
  localparam logic [HCNT_W:0] HACT = (HCNT_W + 1)'(H_ACT);
  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else if (line_end && (({1'b0, x_q} + (HCNT_W + 1)'(1)) != HACT)) err_q <= 1'b1;
  end

  assign o_err      = err_q;
  assign unused_sig = vs_fall;
`else
  assign o_err      = 1'b0;
  assign unused_sig = ^{vs_fall, H_ACT};
`endif

endmodule
